// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART definitions. Holds the parity-mode codes, the    |
// |               transmitter FSM state encoding and the parity helpers. The   |
// |               receiver is expected to import the same package.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package uart_pkg;

  // Parity mode codes as presented on parity_mode
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;  // reserved code, behaves as none

  // Transmitter FSM encoding. The two break states exist only when the
  // break feature is compiled in; the encoding is kept stable either way.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_BREAK     = 3'd5,
    ST_BRK_STOP  = 3'd6
  } uart_state_e;

  // True when the mode carries a parity bit
  function automatic logic parity_enabled(input logic [1:0] mode);
    return !((mode == PAR_NONE) || (mode == PAR_RSVD));
  endfunction

  // Parity bit from the XOR-reduction of the data word
  function automatic logic parity_bit(input logic [1:0] mode, input logic red_xor);
    logic r;
    case (mode)
      PAR_EVEN: r = red_xor;
      PAR_ODD:  r = ~red_xor;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                               |
// | Description : Single-clock FIFO, DATA_W x DEPTH (DEPTH a power of 2).      |
// |               Writes while full are dropped and flagged on overflow_o for  |
// |               one cycle. Head word is visible on rd_data_o (show-ahead).   |
// | Ports       : clk, rst (sync, active high)                                 |
// |               wr_en_i/wr_data_i  push request and data                     |
// |               rd_en_i            pop head (ignored when empty)             |
// |               rd_data_o          current head word                         |
// |               count_o/full_o/empty_o  occupancy                            |
// |               overflow_o         high the cycle after a dropped write      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              ovf_q;
  logic              w_push;
  logic              w_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // Acceptance is decided on the registered full flag, so a simultaneous
  // pop does not make room for a write in the same cycle.
  assign w_push = wr_en_i && !full_o;
  assign w_pop  = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= wr_en_i && full_o;
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : UART transmitter with write FIFO and baud divider. Frames    |
// |               are start, DATA_W bits LSB first, optional parity, 1 or 2    |
// |               stop bits. Configuration is latched at frame start.          |
// | Options     : UART_TX_BREAK_EN adds send_break and a line-break state.     |
// | Ports       : clk, rst (sync, active high)                                 |
// |               baud_div     clocks per bit minus 1                          |
// |               parity_mode  00 none, 01 even, 10 odd, 11 none               |
// |               two_stop     select 2 stop bits                              |
// |               wr_en/wr_data  FIFO push                                     |
// |               send_break   (option) hold line low while idle               |
// |               full, fifo_count, overflow  FIFO status                      |
// |               tx           registered serial line, idle high               |
// |               tx_busy      frame in progress (aligned with tx)             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy
);

  import uart_pkg::*;

  localparam int BC_W = $clog2(DATA_W);

  uart_state_e       state_q, state_d;
  logic [DIV_W-1:0]  timer_q, timer_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              two_stop_q, two_stop_d;
  logic              stop2_q, stop2_d;     // second stop bit in progress
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic              w_pop;
  logic              w_load;
  logic              w_empty;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_head;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (w_pop),
    .rd_data_o  (w_head),
    .count_o    (fifo_count),
    .full_o     (full),
    .empty_o    (w_empty),
    .overflow_o (overflow)
  );

  assign w_bit_end = (timer_q == '0);
  assign tx        = tx_q;
  assign tx_busy   = busy_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    w_load     = 1'b0;
    w_pop      = 1'b0;
    // Every active state reloads the timer at a bit boundary
    timer_d    = w_bit_end ? div_q : timer_q - DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        timer_d = timer_q;
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_d    = ST_BREAK;
          div_d      = baud_div;
          two_stop_d = two_stop;
          stop2_d    = 1'b0;
        end else if (!w_empty) begin
          w_load = 1'b1;
        end
`else
        if (!w_empty) w_load = 1'b1;
`endif
      end
      ST_START: begin
        if (w_bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BC_W'(DATA_W-1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
            stop2_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (two_stop_q && !stop2_q) stop2_d = 1'b1;
          else if (!w_empty)          w_load  = 1'b1;  // back-to-back frame
          else                        state_d = ST_IDLE;
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        timer_d = div_q;
        if (!send_break) state_d = ST_BRK_STOP;
      end
      ST_BRK_STOP: begin
        if (w_bit_end) begin
          if (two_stop_q && !stop2_q) stop2_d = 1'b1;
          else                        state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: pop the head and latch this frame's configuration
    if (w_load) begin
      w_pop      = 1'b1;
      state_d    = ST_START;
      shift_d    = w_head;
      div_d      = baud_div;
      timer_d    = baud_div;
      par_en_d   = parity_enabled(parity_mode);
      par_bit_d  = parity_bit(parity_mode, ^w_head);
      two_stop_d = two_stop;
      stop2_d    = 1'b0;
    end
  end

  // Output logic; registered one cycle behind the state
  always_comb begin
    busy_d = (state_q != ST_IDLE);
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_d = 1'b0;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_fifo                                              |
// | Description : Self-checking bench for uart_tx_fifo. A queue-based line     |
// |               model predicts tx/tx_busy/FIFO status every cycle; directed  |
// |               frames pin the model with literal waveforms.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIV_W-1:0]  baud_div = '0;
  logic [1:0]        parity_mode = 2'b00;
  logic              two_stop = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
`ifdef UART_TX_BREAK_EN
  logic              send_break = 1'b0;
`endif
  logic              full;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic              tx;
  logic              tx_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
`ifdef UART_TX_BREAK_EN
    .send_break  (send_break),
`endif
    .full        (full),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .tx          (tx),
    .tx_busy     (tx_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line model: a queue of accepted words and a queue of per-cycle line values.
  // A frame is expanded into its full per-clock waveform when the line is free.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mq[$];
  bit                sched[$];
  bit                exp_tx   = 1'b1;
  bit                exp_busy = 1'b0;
  bit                exp_ovf  = 1'b0;
  bit                model_ok = 1'b0;

  task automatic push_bits(input bit v, input int n);
    repeat (n) sched.push_back(v);
  endtask

  task automatic model_step();
    int                cnt;
    int                ones;
    int                bt;
    logic [DATA_W-1:0] w;
    if (rst) begin
      mq.delete();
      sched.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_ovf  = 1'b0;
      model_ok = 1'b1;
      return;
    end
    cnt = mq.size();
    if (sched.size() > 0) begin
      exp_tx   = sched.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    if (sched.size() == 0 && cnt > 0) begin
      w    = mq.pop_front();
      bt   = int'(baud_div) + 1;
      ones = 0;
      push_bits(1'b0, bt);
      for (int i = 0; i < DATA_W; i++) begin
        push_bits(w[i], bt);
        ones += int'(w[i]);
      end
      if (parity_mode == 2'b01) push_bits(bit'(ones % 2), bt);
      if (parity_mode == 2'b10) push_bits(bit'(1 - (ones % 2)), bt);
      push_bits(1'b1, two_stop ? 2 * bt : bt);
    end
    exp_ovf = wr_en && (cnt == FIFO_DEPTH);
    if (wr_en && cnt < FIFO_DEPTH) mq.push_back(wr_data);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("tx", 32'(tx), 32'(exp_tx));
        check("tx_busy", 32'(tx_busy), 32'(exp_busy));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("full", 32'(full), 32'(mq.size() == FIFO_DEPTH));
        check("overflow", 32'(overflow), 32'(exp_ovf));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  logic [63:0] cap_tx;
  logic [63:0] cap_busy;

  task automatic write_word(input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Sample n cycles starting at the current falling edge
  task automatic capture(input int n);
    cap_tx   = '1;
    cap_busy = '0;
    for (int j = 0; j < n; j++) begin
      cap_tx[j]   = tx;
      cap_busy[j] = tx_busy;
      @(negedge clk);
    end
  endtask

  function automatic int first_low(input logic [63:0] v);
    for (int j = 0; j < 64; j++) if (v[j] == 1'b0) return j;
    return -1;
  endfunction

  function automatic int ones64(input logic [63:0] v);
    int n = 0;
    for (int j = 0; j < 64; j++) n += int'(v[j]);
    return n;
  endfunction

  initial begin
    logic [10:0] pat1;
    logic [11:0] pat2;
    int ovf_n;
    int busy_n;
    int hi_n;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Frame 1: div 3, even parity, 1 stop, 8'h4D
    baud_div = 16'd3; parity_mode = 2'b01; two_stop = 1'b0;
    pat1 = 11'b10010011010;
    write_word(8'h4D);
    capture(50);
    check("f1_latency", 32'(first_low(cap_tx)), 32'd2);
    for (int b = 0; b < 11; b++) check("f1_bit", 32'(cap_tx[2 + 4*b + 1]), 32'(pat1[b]));
    check("f1_busy_len", 32'(ones64(cap_busy)), 32'd44);
    check("f1_idle_after", 32'(cap_busy[46]), 32'd0);

    // Frame 2: odd parity, 2 stop, 8'hB3
    parity_mode = 2'b10; two_stop = 1'b1;
    pat2 = 12'b110101100110;
    write_word(8'hB3);
    capture(56);
    for (int b = 0; b < 12; b++) check("f2_bit", 32'(cap_tx[2 + 4*b + 1]), 32'(pat2[b]));
    check("f2_parity", 32'(cap_tx[39]), 32'd0);
    hi_n = 0;
    for (int j = 42; j < 50; j++) hi_n += int'(cap_tx[j]);
    check("f2_stop_high", 32'(hi_n), 32'd8);
    check("f2_busy_len", 32'(ones64(cap_busy)), 32'd48);
    check("f2_busy_end", 32'(cap_busy[50]), 32'd0);

    // FIFO stress: 7 consecutive writes into depth 4
    baud_div = 16'd1; parity_mode = 2'b00; two_stop = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h10;
    ovf_n = 0; busy_n = 0;
    for (int j = 1; j <= 130; j++) begin
      @(negedge clk);
      if (overflow) ovf_n++;
      if (tx_busy) busy_n++;
      if (j < 7) wr_data = 8'h10 + 8'(j);
      else       wr_en = 1'b0;
      if (j == 7) begin
        check("st_full", 32'(full), 32'd1);
        check("st_count", 32'(fifo_count), 32'd4);
      end
    end
    check("st_ovf_cycles", 32'(ovf_n), 32'd2);
    check("st_busy_total", 32'(busy_n), 32'd100);

    // Reset during data bit 3
    baud_div = 16'd3;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    repeat (4) @(negedge clk);
    write_word(8'hC4);
    capture(46);
    check("post_rst_latency", 32'(first_low(cap_tx)), 32'd2);
    check("post_rst_busy_len", 32'(ones64(cap_busy)), 32'd40);

    // Parity none -> odd mid-frame
    baud_div = 16'd1; parity_mode = 2'b00; two_stop = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h01;
    busy_n = 0;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      if (tx_busy) busy_n++;
      if (j == 1) wr_data = 8'h02;
      if (j == 2) wr_en = 1'b0;
      if (j == 6) parity_mode = 2'b10;
    end
    check("par_change_busy", 32'(busy_n), 32'd42);

    // Randomized traffic with config changes and occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = DATA_W'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        baud_div    = DIV_W'($urandom_range(0, 3));
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b0;
    repeat (400) @(negedge clk);
    check("drain_busy", 32'(tx_busy), 32'd0);
    check("drain_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
